// File: rtl/afvip_rst_ctrl.sv
// AFVIP interface reset generator: synchronized power-on reset with a fixed hold,
// plus on-demand reset pulses requested over a valid/ready handshake.
module afvip_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter int EVT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_len,
  output logic             req_ready,
  output logic             intf_reset,
  output logic             rst_done,
  output logic [EVT_W-1:0] rst_count
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_ASSERT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [EVT_W-1:0] EVT_ONE   = {{(EVT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_MAX   = {EVT_W{1'b1}};

  state_t                 state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r, sync_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   intf_reset_r, intf_nxt_s;
  logic                   req_ready_r;
  logic                   rst_done_r, done_nxt_s;
  logic [EVT_W-1:0]       rst_count_r, count_nxt_s;

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt_s = state_r;
    sync_nxt_s  = sync_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_SYNC: begin
        // The release chain fills with ones; the last stage going high ends SYNC.
        sync_nxt_s = {sync_r[SYNC_STAGES-2:0], 1'b1};
        if (sync_nxt_s[SYNC_STAGES-1]) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = HOLD_LEN;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_HOLD, ST_ASSERT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (req_valid && req_ready_r) begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = (req_len == CNT_ZERO) ? HOLD_LEN : req_len;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_SYNC;
      end
    endcase

    intf_nxt_s = (state_nxt_s == ST_RUN);
    done_nxt_s = intf_nxt_s & ~intf_reset_r;
    if (done_nxt_s && (rst_count_r != EVT_MAX)) begin
      count_nxt_s = rst_count_r + EVT_ONE;
    end else begin
      count_nxt_s = rst_count_r;
    end
  end

  // State and registered outputs; rst_n aborts everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SYNC;
      sync_r       <= {SYNC_STAGES{1'b0}};
      cnt_r        <= CNT_ZERO;
      intf_reset_r <= 1'b0;
      req_ready_r  <= 1'b0;
      rst_done_r   <= 1'b0;
      rst_count_r  <= {EVT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      sync_r       <= sync_nxt_s;
      cnt_r        <= cnt_nxt_s;
      intf_reset_r <= intf_nxt_s;
      req_ready_r  <= intf_nxt_s;
      rst_done_r   <= done_nxt_s;
      rst_count_r  <= count_nxt_s;
    end
  end

  assign intf_reset = intf_reset_r;
  assign req_ready  = req_ready_r;
  assign rst_done   = rst_done_r;
  assign rst_count  = rst_count_r;

endmodule

// File: tb/tb_afvip_rst_ctrl.sv
// Directed bench for afvip_rst_ctrl: POR timing, requested and default pulses,
// back-to-back requests, asynchronous abort and counter saturation (EVT_W = 2 copy).
module tb_afvip_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_len;
  logic       req_ready, intf_reset, rst_done;
  logic [7:0] rst_count;
  logic       s_req_ready, s_intf_reset, s_rst_done;
  logic [1:0] s_rst_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  afvip_rst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .intf_reset(intf_reset), .rst_done(rst_done),
    .rst_count(rst_count)
  );

  afvip_rst_ctrl #(.EVT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len),
    .req_ready(s_req_ready), .intf_reset(s_intf_reset), .rst_done(s_rst_done),
    .rst_count(s_rst_count)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release rst_n mid-cycle and follow the POR sequence to its done pulse.
  task automatic por_release();
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check_val("por_low", int'(intf_reset), 0);
      check_val("por_ready_low", int'(req_ready), 0);
      check_val("por_done_low", int'(rst_done), 0);
    end
    tick();
    check_val("por_high_e18", int'(intf_reset), 1);
    check_val("por_done", int'(rst_done), 1);
    check_val("por_count", int'(rst_count), 1);
    check_val("por_ready", int'(req_ready), 1);
    check_val("por_sat_count", int'(s_rst_count), 1);
    tick();
    check_val("por_done_once", int'(rst_done), 0);
    check_val("por_still_high", int'(intf_reset), 1);
  endtask

  // One requested pulse; called while in RUN, returns just after the done edge.
  task automatic do_pulse(input logic [7:0] len, input int low_cycles,
                          input int exp_cnt, input int exp_sat, input bit keep_valid);
    req_valid = 1'b1;
    req_len   = len;
    check_val("hs_high", int'(intf_reset), 1);
    check_val("hs_ready", int'(req_ready), 1);
    for (int i = 0; i < low_cycles; i++) begin
      tick();
      if (i == 0 && !keep_valid) begin
        req_valid = 1'b0;
        req_len   = 8'd2;
      end
      check_val("pulse_low", int'(intf_reset), 0);
      check_val("pulse_ready_low", int'(req_ready), 0);
      check_val("pulse_done_low", int'(rst_done), 0);
    end
    tick();
    check_val("pulse_end_high", int'(intf_reset), 1);
    check_val("pulse_done", int'(rst_done), 1);
    check_val("pulse_count", int'(rst_count), exp_cnt);
    check_val("sat_done", int'(s_rst_done), 1);
    check_val("sat_count", int'(s_rst_count), exp_sat);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_len   = 8'd0;
    #1;
    check_val("rst_intf", int'(intf_reset), 0);
    check_val("rst_ready", int'(req_ready), 0);
    check_val("rst_done0", int'(rst_done), 0);
    check_val("rst_count0", int'(rst_count), 0);
    // Requests while in reset must be ignored.
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req_valid = 1'b0;
    check_val("rst_hold_intf", int'(intf_reset), 0);

    por_release();

    do_pulse(8'd5, 5, 2, 2, 1'b0);
    tick();
    check_val("after5_done_clr", int'(rst_done), 0);
    do_pulse(8'd0, 16, 3, 3, 1'b0);
    tick();

    do_pulse(8'd3, 3, 4, 3, 1'b1);
    do_pulse(8'd3, 3, 5, 3, 1'b1);
    do_pulse(8'd3, 3, 6, 3, 1'b1);
    req_valid = 1'b0;
    tick();
    check_val("b2b_no_extra", int'(intf_reset), 1);
    check_val("b2b_count_hold", int'(rst_count), 6);

    // Abort a 10-cycle pulse during its third low cycle.
    req_valid = 1'b1;
    req_len   = 8'd10;
    tick();
    req_valid = 1'b0;
    check_val("abort_low1", int'(intf_reset), 0);
    tick();
    tick();
    check_val("abort_low3", int'(intf_reset), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_intf", int'(intf_reset), 0);
    check_val("abort_count", int'(rst_count), 0);
    check_val("abort_ready", int'(req_ready), 0);
    check_val("abort_sat_count", int'(s_rst_count), 0);
    tick();
    tick();
    check_val("abort_hold", int'(intf_reset), 0);
    por_release();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
